// File: rtl/note_detector.sv
// note_detector: measures the period of a 1-bit square-wave input and reports
// which of six notes (C,D,E,F,G,A) it matches, once the same class has been
// seen on CONFIRM consecutive periods. Silence is detected by a period timeout.
module note_detector #(
  parameter int unsigned CLK_FREQ = 25000000,
  parameter int unsigned TOL      = 1000,
  parameter int unsigned CONFIRM  = 3,
  parameter int unsigned TIMEOUT  = 131072
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sound_in,
  output logic       note_valid,
  output logic [2:0] note_id,
  output logic [5:0] note_onehot,
  output logic       note_change
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  localparam int unsigned KW = $clog2(CONFIRM + 1);

  // Nominal period in clocks for each note frequency.
  localparam int unsigned P_C = 2 * (CLK_FREQ / (2 * 262) + 1);
  localparam int unsigned P_D = 2 * (CLK_FREQ / (2 * 294) + 1);
  localparam int unsigned P_E = 2 * (CLK_FREQ / (2 * 330) + 1);
  localparam int unsigned P_F = 2 * (CLK_FREQ / (2 * 349) + 1);
  localparam int unsigned P_G = 2 * (CLK_FREQ / (2 * 392) + 1);
  localparam int unsigned P_A = 2 * (CLK_FREQ / (2 * 440) + 1);

  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT);
  localparam logic [KW-1:0] CNT_CONFIRM = KW'(CONFIRM);

  // Class encoding doubles as the note_id output encoding (NONE shows as 7).
  typedef enum logic [2:0] {
    NOTE_C    = 3'd0,
    NOTE_D    = 3'd1,
    NOTE_E    = 3'd2,
    NOTE_F    = 3'd3,
    NOTE_G    = 3'd4,
    NOTE_A    = 3'd5,
    NOTE_NONE = 3'd7
  } note_e;

  typedef enum logic {
    DISARMED = 1'b0,
    ARMED    = 1'b1
  } arm_e;

  logic          sync1, sync2, sync3;
  logic          rise;
  logic [CW-1:0] cnt, cnt_n;
  logic [KW-1:0] count, count_n;
  logic [31:0]   period;
  note_e         cls;
  note_e         cand, cand_n;
  note_e         out_id, id_n;
  arm_e          state, state_n;
  logic          valid_n, change_n;

  // Written as per + TOL >= nom so that nom - TOL can never underflow.
  function automatic logic in_window(input logic [31:0] per, input int unsigned nom);
    return (per + TOL >= nom) && (per <= nom + TOL);
  endfunction

  // Two-flop synchroniser plus one delay flop for rising-edge detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      sync3 <= 1'b0;
    end else begin
      sync1 <= sound_in;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  assign rise   = sync2 & ~sync3;
  assign period = {{(32 - CW){1'b0}}, cnt};

  // Classify the current counter value as a period; windows never overlap.
  always_comb begin
    cls = NOTE_NONE;
    if      (in_window(period, P_C)) cls = NOTE_C;
    else if (in_window(period, P_D)) cls = NOTE_D;
    else if (in_window(period, P_E)) cls = NOTE_E;
    else if (in_window(period, P_F)) cls = NOTE_F;
    else if (in_window(period, P_G)) cls = NOTE_G;
    else if (in_window(period, P_A)) cls = NOTE_A;
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= DISARMED;
      cnt         <= '0;
      cand        <= NOTE_NONE;
      count       <= '0;
      out_id      <= NOTE_NONE;
      note_valid  <= 1'b0;
      note_change <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      cand        <= cand_n;
      count       <= count_n;
      out_id      <= id_n;
      note_valid  <= valid_n;
      note_change <= change_n;
    end
  end

  // Arm/streak/timeout next-state logic; a rise takes priority over timeout,
  // so a rise on the saturated count is classified (as NONE) rather than dropped.
  always_comb begin
    state_n  = state;
    cnt_n    = (cnt == CNT_MAX) ? cnt : cnt + CW'(1);
    cand_n   = cand;
    count_n  = count;
    id_n     = out_id;
    valid_n  = note_valid;
    change_n = 1'b0;
    if (rise) begin
      cnt_n = CW'(1);
      if (state == DISARMED) begin
        state_n = ARMED;
      end else begin
        if (cls == cand) begin
          if (count != CNT_CONFIRM) count_n = count + KW'(1);
        end else begin
          cand_n  = cls;
          count_n = KW'(1);
        end
        if (count_n == CNT_CONFIRM && cand_n != out_id) begin
          id_n     = cand_n;
          valid_n  = (cand_n != NOTE_NONE);
          change_n = 1'b1;
        end
      end
    end else if (state == ARMED && cnt == CNT_MAX) begin
      state_n  = DISARMED;
      cand_n   = NOTE_NONE;
      count_n  = '0;
      id_n     = NOTE_NONE;
      valid_n  = 1'b0;
      change_n = note_valid;
    end
  end

  assign note_id = out_id;

  // One-hot view of the registered note, same bit order as the generator.
  always_comb begin
    note_onehot = '0;
    if (note_valid) begin
      case (out_id)
        NOTE_C:  note_onehot = 6'b000001;
        NOTE_D:  note_onehot = 6'b000010;
        NOTE_E:  note_onehot = 6'b000100;
        NOTE_F:  note_onehot = 6'b001000;
        NOTE_G:  note_onehot = 6'b010000;
        NOTE_A:  note_onehot = 6'b100000;
        default: note_onehot = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_note_detector.sv
// Testbench for note_detector: directed scenarios plus randomized periods,
// checked against a period-level reference model of the note classifier.
module tb_note_detector;

  localparam int unsigned CLK_FREQ = 125000;
  localparam int unsigned TOL      = 4;
  localparam int unsigned CONFIRM  = 3;
  localparam int unsigned TIMEOUT  = 1024;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       sound_in = 1'b0;
  logic       note_valid;
  logic [2:0] note_id;
  logic [5:0] note_onehot;
  logic       note_change;

  note_detector #(
    .CLK_FREQ(CLK_FREQ),
    .TOL(TOL),
    .CONFIRM(CONFIRM),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .sound_in(sound_in),
    .note_valid(note_valid),
    .note_id(note_id),
    .note_onehot(note_onehot),
    .note_change(note_change)
  );

  always #5 clk = ~clk;

  // Free-running cycle count; bench actions happen 1 time unit after posedge.
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Running total of clocks with note_change high, sampled mid-cycle.
  int unsigned pulse_total = 0;
  always @(negedge clk) if (note_change === 1'b1) pulse_total <= pulse_total + 1;

  int n_tests = 0;
  int n_fail  = 0;

  int freqs [6] = '{262, 294, 330, 349, 392, 440};
  int nom [6];

  // Reference model state: armed flag, recent period classes, current output.
  bit m_armed;
  int m_hist [$];
  int m_out;

  int unsigned last_rise;
  int unsigned pulse_mark;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int classify(input int per);
    for (int x = 0; x < 6; x++)
      if (per >= nom[x] - int'(TOL) && per <= nom[x] + int'(TOL)) return x;
    return 7;
  endfunction

  function automatic void model_reset();
    m_armed = 1'b0;
    m_hist.delete();
    m_out = 7;
  endfunction

  // Silence longer than TIMEOUT while armed: returns expected change pulses.
  function automatic int model_timeout(input int gap);
    int p = 0;
    if (m_armed && gap > int'(TIMEOUT)) begin
      if (m_out != 7) p = 1;
      model_reset();
    end
    return p;
  endfunction

  // A rising edge gap clocks after the previous one: returns 1 if output changes.
  function automatic int model_rise(input int gap);
    int per, c;
    bit same;
    if (!m_armed) begin
      m_armed = 1'b1;
      return 0;
    end
    per = (gap >= int'(TIMEOUT)) ? int'(TIMEOUT) : gap;
    c = classify(per);
    m_hist.push_back(c);
    if (m_hist.size() > CONFIRM) void'(m_hist.pop_front());
    if (m_hist.size() != CONFIRM) return 0;
    same = 1'b1;
    foreach (m_hist[i]) if (m_hist[i] != m_hist[0]) same = 1'b0;
    if (same && m_hist[0] != m_out) begin
      m_out = m_hist[0];
      return 1;
    end
    return 0;
  endfunction

  task automatic wait_until(input int unsigned target);
    while (cyc < target) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_outputs(input string tag, input int exp_out);
    logic [5:0] oh;
    oh = (exp_out == 7) ? 6'd0 : 6'(1 << exp_out);
    check({tag, "_valid"}, note_valid, (exp_out != 7) ? 1 : 0);
    check({tag, "_id"}, note_id, exp_out);
    check({tag, "_onehot"}, note_onehot, oh);
  endtask

  // Produce one period of p clocks, ending in the rise that measures it.
  task automatic send(input int p);
    int tp, rp, pre;
    wait_until(last_rise + p / 2);
    sound_in = 1'b0;
    wait_until(last_rise + p);
    sound_in = 1'b1;
    last_rise = cyc;
    tp  = model_timeout(p);
    pre = m_out;
    rp  = model_rise(p);
    wait_until(last_rise + 2);
    check_outputs("latency", pre);
    wait_until(last_rise + 3);
    check_outputs("rise", m_out);
    check("change_pulse", note_change, rp);
    check("pulses_between", pulse_total - pulse_mark, tp);
    pulse_mark = pulse_total + (note_change ? 1 : 0);
  endtask

  task automatic send_n(input int p, input int n);
    for (int i = 0; i < n; i++) send(p);
  endtask

  task automatic apply_reset();
    sound_in = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    check_outputs("reset", 7);
    check("reset_change", note_change, 0);
    @(posedge clk);
    #1;
    check("post_reset_change", note_change, 0);
    pulse_mark = pulse_total;
    last_rise = cyc;
  endtask

  // Hold the input low after a rise and check the timeout edge exactly.
  task automatic go_silent(input string tag);
    int tp;
    sound_in = 1'b0;
    wait_until(last_rise + 2 + TIMEOUT);
    check_outputs({tag, "_before"}, m_out);
    wait_until(last_rise + 3 + TIMEOUT);
    tp = model_timeout(int'(TIMEOUT) + 1);
    check_outputs({tag, "_after"}, 7);
    check({tag, "_pulse"}, note_change, tp);
    check({tag, "_pulses_between"}, pulse_total - pulse_mark, 0);
    pulse_mark = pulse_total + (note_change ? 1 : 0);
    last_rise = cyc;
  endtask

  initial begin
    int r, len, p, nt;
    for (int x = 0; x < 6; x++) nom[x] = 2 * (int'(CLK_FREQ) / (2 * freqs[x]) + 1);
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    apply_reset();

    // C acquisition: first rise arms, next three confirm.
    send_n(nom[0], 3);
    check_outputs("c_not_yet", 7);
    send(nom[0]);
    check_outputs("c_confirmed", 0);

    // C to A with no intermediate invalid state.
    send_n(nom[5], 2);
    check_outputs("a_not_yet", 0);
    send(nom[5]);
    check_outputs("a_confirmed", 5);

    go_silent("timeout");

    // E stream, single off-note period, then a confirmed off-note.
    send_n(nom[2], 4);
    check_outputs("e_confirmed", 2);
    send(403);
    send(nom[2]);
    check_outputs("e_held", 2);
    send_n(403, 3);
    check_outputs("between_de", 7);

    // Tolerance edges around E.
    send_n(nom[2] + int'(TOL), 3);
    check_outputs("e_plus_tol", 2);
    send_n(nom[2] + int'(TOL) + 1, 3);
    check_outputs("e_plus_tol1", 7);
    send_n(nom[2] - int'(TOL), 3);
    check_outputs("e_minus_tol", 2);
    send_n(nom[2] - int'(TOL) - 1, 3);
    check_outputs("e_minus_tol1", 7);

    // Reset while A is valid, then re-acquire with four rises.
    send_n(nom[5], 3);
    check_outputs("a_valid", 5);
    apply_reset();
    send_n(nom[5], 3);
    check_outputs("reacq_3", 7);
    send(nom[5]);
    check_outputs("reacq_4", 5);

    // Rise exactly at the timeout count is a saturated (NONE) period.
    send_n(int'(TIMEOUT), 3);
    check_outputs("sat_period", 7);

    // Randomized periods: near-nominal, arbitrary, and long gaps.
    for (int it = 0; it < 25; it++) begin
      r   = int'($urandom_range(0, 9));
      len = int'($urandom_range(1, 4));
      nt  = int'($urandom_range(0, 5));
      for (int k = 0; k < len; k++) begin
        if (r < 6)
          p = nom[r] + int'($urandom_range(0, 2 * TOL + 2)) - int'(TOL + 1);
        else if (r < 8)
          p = int'($urandom_range(250, 600));
        else if (r == 8)
          p = int'(TIMEOUT) + int'($urandom_range(0, 40));
        else
          p = nom[nt];
        send(p);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
